// File: rtl/radix5_stage_ctrl_pkg.sv
// Shared definitions for the radix-5 stage controller: FSM states,
// the number of butterfly input slots and the default butterfly latency.
package radix5_stage_ctrl_pkg;

  localparam int R5_SLOTS          = 5;
  localparam int R5_BF_LAT_DEFAULT = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN
  } r5_state_e;

endpackage

// File: rtl/r5_valid_dly.sv
// Fixed-depth 1-bit delay line that tracks the butterfly result valid
// alongside the external butterfly pipeline.
module r5_valid_dly #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift the valid bit one stage per cycle; reset flushes every stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/radix5_stage_ctrl.sv
// Radix-5 stage controller: groups incoming samples into five-slot
// butterflies, issues them back-to-back, and tracks frame completion.
module radix5_stage_ctrl
  import radix5_stage_ctrl_pkg::*;
#(
  parameter int DW     = 32,
  parameter int BF_LAT = R5_BF_LAT_DEFAULT,
  parameter int NBF    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [DW-1:0]          in_re,
  input  logic [DW-1:0]          in_img,
  output logic                   in_ready,
  output logic [R5_SLOTS*DW-1:0] bf_re,
  output logic [R5_SLOTS*DW-1:0] bf_img,
  output logic                   bf_go,
  output logic [2:0]             bf_idx,
  output logic                   res_valid,
  output logic                   frame_done,
  output logic                   err_sof
);

  localparam logic [2:0] LAST_SLOT = 3'(R5_SLOTS - 1);
  localparam logic [2:0] LAST_BF   = 3'(NBF - 1);
  localparam logic [3:0] LAT_LOAD  = 4'(BF_LAT);

  r5_state_e state_q, state_d;

  logic [2:0] slot_q, slot_d;
  logic [2:0] bfCnt_q, bfCnt_d;
  logic [3:0] drainCnt_q, drainCnt_d;

  logic [DW-1:0] slotRe_q [R5_SLOTS-1];
  logic [DW-1:0] slotRe_d [R5_SLOTS-1];
  logic [DW-1:0] slotIm_q [R5_SLOTS-1];
  logic [DW-1:0] slotIm_d [R5_SLOTS-1];

  logic [R5_SLOTS*DW-1:0] bfRe_q, bfRe_d, bfIm_q, bfIm_d;
  logic                   bfGo_q, bfGo_d;
  logic [2:0]             bfIdx_q, bfIdx_d;
  logic                   errSof_q, errSof_d;

  logic accept, firstSlot, sofErr, restart, collectStore, issue, lastIssue;

  // Decode the handshake into the events that steer both FSM and datapath
  always_comb begin
    accept       = in_valid & in_ready;
    firstSlot    = (slot_q == '0) && (bfCnt_q == '0);
    sofErr       = (state_q == ST_COLLECT) && accept && in_sof && !firstSlot;
    restart      = ((state_q == ST_IDLE) && accept && in_sof) || sofErr;
    collectStore = (state_q == ST_COLLECT) && accept && !sofErr;
    issue        = collectStore && (slot_q == LAST_SLOT);
    lastIssue    = issue && (bfCnt_q == LAST_BF);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a frame starts on sof, ends after the last butterfly drains
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (restart)            state_d = ST_COLLECT;
      ST_COLLECT: if (lastIssue)          state_d = ST_DRAIN;
      ST_DRAIN:   if (drainCnt_q == '0)   state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: backpressure while draining, done when the final result lands
  always_comb begin
    in_ready   = (state_q != ST_DRAIN);
    frame_done = (state_q == ST_DRAIN) && (drainCnt_q == '0);
  end

  // Datapath next state: slot fill, butterfly issue and drain countdown
  always_comb begin
    slot_d     = slot_q;
    bfCnt_d    = bfCnt_q;
    drainCnt_d = drainCnt_q;
    slotRe_d   = slotRe_q;
    slotIm_d   = slotIm_q;
    bfRe_d     = bfRe_q;
    bfIm_d     = bfIm_q;
    bfIdx_d    = bfIdx_q;
    bfGo_d     = issue;
    errSof_d   = sofErr;

    if (restart) begin
      slotRe_d[0] = in_re;
      slotIm_d[0] = in_img;
      slot_d      = 3'd1;
      bfCnt_d     = '0;
    end else if (collectStore) begin
      if (issue) begin
        for (int k = 0; k < R5_SLOTS - 1; k++) begin
          bfRe_d[k*DW +: DW] = slotRe_q[k];
          bfIm_d[k*DW +: DW] = slotIm_q[k];
        end
        bfRe_d[(R5_SLOTS-1)*DW +: DW] = in_re;
        bfIm_d[(R5_SLOTS-1)*DW +: DW] = in_img;
        bfIdx_d = bfCnt_q;
        slot_d  = '0;
        bfCnt_d = lastIssue ? 3'd0 : bfCnt_q + 3'd1;
      end else begin
        slotRe_d[slot_q[1:0]] = in_re;
        slotIm_d[slot_q[1:0]] = in_img;
        slot_d = slot_q + 3'd1;
      end
    end

    if (lastIssue) begin
      drainCnt_d = LAT_LOAD;
    end else if ((state_q == ST_DRAIN) && (drainCnt_q != '0)) begin
      drainCnt_d = drainCnt_q - 4'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q     <= '0;
      bfCnt_q    <= '0;
      drainCnt_q <= '0;
      for (int k = 0; k < R5_SLOTS - 1; k++) begin
        slotRe_q[k] <= '0;
        slotIm_q[k] <= '0;
      end
      bfRe_q   <= '0;
      bfIm_q   <= '0;
      bfGo_q   <= 1'b0;
      bfIdx_q  <= '0;
      errSof_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      bfCnt_q    <= bfCnt_d;
      drainCnt_q <= drainCnt_d;
      slotRe_q   <= slotRe_d;
      slotIm_q   <= slotIm_d;
      bfRe_q     <= bfRe_d;
      bfIm_q     <= bfIm_d;
      bfGo_q     <= bfGo_d;
      bfIdx_q    <= bfIdx_d;
      errSof_q   <= errSof_d;
    end
  end

  r5_valid_dly #(
    .DEPTH (BF_LAT)
  ) u_valid_dly (
    .clk    (clk),
    .rst    (rst),
    .din_i  (bfGo_q),
    .dout_o (res_valid)
  );

  assign bf_re   = bfRe_q;
  assign bf_img  = bfIm_q;
  assign bf_go   = bfGo_q;
  assign bf_idx  = bfIdx_q;
  assign err_sof = errSof_q;

endmodule

// File: tb/tb_radix5_stage_ctrl.sv
// Self-checking bench for radix5_stage_ctrl: a cycle-aware reference model
// pushes expected butterflies and pulse times into queues as samples are
// driven, and a negedge monitor pops and compares them as the DUT responds.
module tb_radix5_stage_ctrl;

  localparam int DW     = 32;
  localparam int BF_LAT = 9;
  localparam int NBF    = 5;

  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_DRAIN   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_sof;
  logic [DW-1:0]   in_re, in_img;
  logic            in_ready;
  logic [5*DW-1:0] bf_re, bf_img;
  logic            bf_go;
  logic [2:0]      bf_idx;
  logic            res_valid, frame_done, err_sof;

  typedef struct {
    int              cyc;
    logic [2:0]      idx;
    logic [5*DW-1:0] re;
    logic [5*DW-1:0] im;
  } bfExp_t;

  bfExp_t bfQ[$];
  int     resQ[$];
  int     doneQ[$];
  int     errQ[$];
  bfExp_t mE;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  int            mState, mSlot, mBf, mDrainUntil;
  logic [DW-1:0] mRe [5];
  logic [DW-1:0] mIm [5];

  radix5_stage_ctrl #(
    .DW     (DW),
    .BF_LAT (BF_LAT),
    .NBF    (NBF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_re      (in_re),
    .in_img     (in_img),
    .in_ready   (in_ready),
    .bf_re      (bf_re),
    .bf_img     (bf_img),
    .bf_go      (bf_go),
    .bf_idx     (bf_idx),
    .res_valid  (res_valid),
    .frame_done (frame_done),
    .err_sof    (err_sof)
  );

  // Free-running 100 MHz-style clock
  always #5 clk = ~clk;

  // Cycle counter used to timestamp expected and observed events
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Forget everything the model expects (used when reset is applied)
  task automatic resetModel();
    bfQ.delete();
    resQ.delete();
    doneQ.delete();
    errQ.delete();
    mState = M_IDLE;
    mSlot  = 0;
    mBf    = 0;
    mDrainUntil = 0;
  endtask

  // Reference behaviour for one accepted sample in the current cycle
  task automatic modelAccept(input logic s, input logic [DW-1:0] re, input logic [DW-1:0] im);
    if (mState == M_IDLE) begin
      if (s) begin
        mRe[0] = re; mIm[0] = im;
        mSlot = 1; mBf = 0; mState = M_COLLECT;
      end
    end else if (s && !(mSlot == 0 && mBf == 0)) begin
      errQ.push_back(cyc + 1);
      mRe[0] = re; mIm[0] = im;
      mSlot = 1; mBf = 0;
    end else begin
      mRe[mSlot] = re; mIm[mSlot] = im;
      if (mSlot == 4) begin
        mE.cyc = cyc + 1;
        mE.idx = 3'(mBf);
        for (int k = 0; k < 5; k++) begin
          mE.re[k*DW +: DW] = mRe[k];
          mE.im[k*DW +: DW] = mIm[k];
        end
        bfQ.push_back(mE);
        resQ.push_back(cyc + 1 + BF_LAT);
        if (mBf == NBF - 1) begin
          doneQ.push_back(cyc + 1 + BF_LAT);
          mDrainUntil = cyc + 1 + BF_LAT;
          mState = M_DRAIN;
          mBf = 0;
        end else begin
          mBf++;
        end
        mSlot = 0;
      end else begin
        mSlot++;
      end
    end
  endtask

  // Drive one cycle of input, check in_ready against the model, advance
  task automatic applyStimulus(input logic v, input logic s, input logic [DW-1:0] re, input logic [DW-1:0] im);
    logic expReady;
    in_valid = v; in_sof = s; in_re = re; in_img = im;
    if (mState == M_DRAIN && cyc > mDrainUntil) mState = M_IDLE;
    expReady = (mState != M_DRAIN);
    checkOutput("in_ready", in_ready, expReady);
    if (v && expReady) modelAccept(s, re, im);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  // Send n samples re=base+k, img=-(base+k), optionally with random gaps
  task automatic runFrame(input int base, input int n, input bit sofFirst, input int gapPct);
    for (int k = 0; k < n; k++) begin
      int g = 0;
      while (g < 8 && $urandom_range(0, 99) < gapPct) begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
        g++;
      end
      applyStimulus(1'b1, sofFirst && (k == 0), DW'(base + k), DW'(-(base + k)));
    end
  endtask

  // Monitor: compare every DUT event against the head of its queue
  always @(negedge clk) begin
    if (bf_go) begin
      if (bfQ.size() == 0) checkOutput("bf_go unexpected", 1, 0);
      else begin
        mE = bfQ.pop_front();
        checkOutput("bf_go cycle", cyc, mE.cyc);
        checkOutput("bf_idx", bf_idx, mE.idx);
        checkOutput("bf_re", bf_re, mE.re);
        checkOutput("bf_img", bf_img, mE.im);
      end
    end else if (bfQ.size() != 0 && bfQ[0].cyc < cyc) begin
      checkOutput("bf_go missing", 0, 1);
      mE = bfQ.pop_front();
    end

    if (res_valid) begin
      if (resQ.size() == 0) checkOutput("res_valid unexpected", 1, 0);
      else checkOutput("res_valid cycle", cyc, resQ.pop_front());
    end else if (resQ.size() != 0 && resQ[0] < cyc) begin
      checkOutput("res_valid missing", 0, resQ.pop_front());
    end

    if (frame_done) begin
      if (doneQ.size() == 0) checkOutput("frame_done unexpected", 1, 0);
      else checkOutput("frame_done cycle", cyc, doneQ.pop_front());
    end else if (doneQ.size() != 0 && doneQ[0] < cyc) begin
      checkOutput("frame_done missing", 0, doneQ.pop_front());
    end

    if (err_sof) begin
      if (errQ.size() == 0) checkOutput("err_sof unexpected", 1, 0);
      else checkOutput("err_sof cycle", cyc, errQ.pop_front());
    end else if (errQ.size() != 0 && errQ[0] < cyc) begin
      checkOutput("err_sof missing", 0, errQ.pop_front());
    end
  end

  // Every output must be at its reset value while reset is held
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " bf_go"}, bf_go, 0);
    checkOutput({tag, " res_valid"}, res_valid, 0);
    checkOutput({tag, " frame_done"}, frame_done, 0);
    checkOutput({tag, " err_sof"}, err_sof, 0);
    checkOutput({tag, " bf_re"}, bf_re, 0);
    checkOutput({tag, " bf_img"}, bf_img, 0);
    checkOutput({tag, " bf_idx"}, bf_idx, 0);
    checkOutput({tag, " in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_img = '0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("por");
    rst = 1'b0;

    // Clean frame, continuous valid: bf_go every 5 cycles, done BF_LAT later
    $display("[TB] clean frame");
    idleCycles(2);
    runFrame(0, 25, 1'b1, 0);
    idleCycles(BF_LAT + 4);

    // Stray samples without sof in IDLE are dropped
    $display("[TB] samples before sof");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, DW'(900 + i), DW'(-(900 + i)));
    runFrame(1000, 25, 1'b1, 0);
    idleCycles(BF_LAT + 4);

    // sof on the 8th sample aborts the frame and restarts the butterfly count
    $display("[TB] misplaced sof");
    runFrame(200, 7, 1'b1, 0);
    runFrame(300, 25, 1'b1, 0);
    idleCycles(BF_LAT + 4);

    // Random gaps must not change the grouped butterfly contents
    $display("[TB] random gaps");
    runFrame(0, 25, 1'b1, 50);
    idleCycles(BF_LAT + 4);

    // A sample offered during DRAIN waits until the frame is done
    $display("[TB] offer during drain");
    runFrame(400, 25, 1'b1, 0);
    for (int i = 0; i < 40 && mState != M_COLLECT; i++) applyStimulus(1'b1, 1'b1, DW'(500), DW'(-500));
    checkOutput("drain sample taken", mState, M_COLLECT);
    runFrame(501, 24, 1'b0, 0);
    idleCycles(BF_LAT + 4);

    // Reset three cycles after butterfly 2 issues wipes everything
    $display("[TB] reset mid-frame");
    runFrame(600, 15, 1'b1, 0);
    runFrame(615, 3, 1'b0, 0);
    rst = 1'b1;
    #1;
    checkResetOutputs("midrst");
    resetModel();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleCycles(20);
    runFrame(700, 25, 1'b1, 0);
    idleCycles(BF_LAT + 4);

    checkOutput("bfQ leftover", bfQ.size(), 0);
    checkOutput("resQ leftover", resQ.size(), 0);
    checkOutput("doneQ leftover", doneQ.size(), 0);
    checkOutput("errQ leftover", errQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/radix5_stage_ctrl.md
RADIX5_STAGE_CTRL -- requirements
Module: radix5_stage_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, meaning bit width of each real and imaginary sample component.
REQ-002 SHALL have parameter BF_LAT, default 9, meaning fixed butterfly-plus-delay-line latency in cycles from bf_go to result; legal range 1..15.
REQ-003 SHALL have parameter NBF, default 5, meaning butterflies per frame; frame length is 5*NBF samples.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input sample valid.
REQ-007 SHALL have port in_sof  input  1  start of frame; qualified by in_valid.
REQ-008 SHALL have port in_re  input  DW  input sample, real part.
REQ-009 SHALL have port in_img  input  DW  input sample, imaginary part.
REQ-010 SHALL have port in_ready  output  1  controller accepts a sample this cycle.
REQ-011 SHALL have port bf_re  output  5*DW  five real parts to butterfly; slot k at bits [k*DW +: DW].
REQ-012 SHALL have port bf_img  output  5*DW  five imaginary parts, same packing.
REQ-013 SHALL have port bf_go  output  1  one-cycle pulse; bf_re/bf_img valid.
REQ-014 SHALL have port bf_idx  output  3  butterfly index in frame, 0..NBF-1, valid with bf_go.
REQ-015 SHALL have port res_valid  output  1  butterfly result valid; bf_go delayed BF_LAT cycles.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse with last res_valid of a frame.
REQ-017 SHALL have port err_sof  output  1  one-cycle pulse on a misplaced sof.

Function
REQ-018 SHALL accept a sample when in_valid and in_ready are both 1.
REQ-019 SHALL implement states IDLE, COLLECT, DRAIN.
REQ-020 IDLE: in_ready=1; accepted sample without in_sof discarded; accepted sample with in_sof stored as slot 0, butterfly 0, next state COLLECT.
REQ-021 COLLECT: in_ready=1; accepted samples fill slots 1..4 in order via a mod-5 slot counter.
REQ-022 SHALL assert bf_go the cycle after the slot-4 sample is accepted, with all five slots on bf_re/bf_img and the current butterfly index on bf_idx; outputs held until next bf_go.
REQ-023 SHALL increment the butterfly counter after each bf_go; after butterfly NBF-1 is issued, next state DRAIN.
REQ-024 In COLLECT, accepted in_sof at slot 0 of butterfly 0 is legal; accepted in_sof anywhere else SHALL pulse err_sof next cycle, discard the partial group and partial frame, and store the sample as slot 0 of butterfly 0.
REQ-025 Consecutive butterflies SHALL be issued back-to-back (no idle cycle needed between slot 4 and next slot 0).
REQ-026 DRAIN: in_ready=0; SHALL remain until the res_valid of butterfly NBF-1, then pulse frame_done that same cycle and go to IDLE.
REQ-027 res_valid SHALL be produced by a BF_LAT-deep valid shift register fed by bf_go; pulses from an aborted frame still emerge, but frame_done counts only the current frame's last butterfly.
REQ-028 in_valid=0 cycles SHALL stall the slot counter without loss.

Reset
REQ-029 On rst: state IDLE, counters 0, valid shift register cleared, bf_go/res_valid/frame_done/err_sof 0, bf_re/bf_img 0, bf_idx 0; in_ready 1 after release.
REQ-030 Reset mid-frame or mid-DRAIN SHALL discard all state; no frame_done and no res_valid after release until a new bf_go.

Structure
REQ-031 Shared package SHALL hold the state enum, slot count constant 5, and default BF_LAT.
REQ-032 One sub-module natural: r5_valid_dly (parameterised BF_LAT-deep 1-bit delay line with async reset).

Verification
REQ-033 Frame of 25 samples re=k, img=-k, sof on k=0, in_valid continuous -> bf_go at cycles 5,10,15,20,25 after first accept, bf_idx 0..4, butterfly 0 holds re {0,1,2,3,4}; frame_done 9 cycles after last bf_go.
REQ-034 Samples without sof in IDLE -> no bf_go, no err_sof; first sof sample becomes slot 0.
REQ-035 in_sof on 8th sample of a frame -> err_sof pulse, bf_idx restarts at 0, butterfly 1 of old frame never issued.
REQ-036 Random in_valid gaps (50%) on 25-sample frame -> identical bf_re/bf_img contents to gap-free run.
REQ-037 Valid sample offered during DRAIN -> in_ready=0, sample not consumed; accepted after frame_done.
REQ-038 rst asserted 3 cycles after bf_go of butterfly 2 -> all outputs 0 immediately, no res_valid/frame_done after release.
